seq_hit_window_counter: RTL
===========================

// Module: seq_hit_window_counter
// PURPOSE
//  Downstream consumer of the serial sequence detector's one-cycle match pulse.
//  - Counts match pulses over fixed windows of WINDOW clock cycles.
//  - At each window end, publishes the count through a valid/ready result port.
//  - Feeds the statistics/readout logic; gives a per-window hit rate of the bitstream.
// PARAMETERS
//  WINDOW  16  cycles per counting window (>=2)
//  CNT_W   8   width of hit count / result; count saturates at 2**CNT_W-1
// PORTS
//  sys_clk    in   1      single clock, all logic on rising edge
//  sys_rst    in   1      reset, asynchronous, active-high
//  en         in   1      run request; sampled in IDLE and at window boundaries
//  hit_in     in   1      match pulse from detector (registered, 1 cycle per match)
//  res_data   out  CNT_W  hit count of last completed window
//  res_valid  out  1      res_data valid; held until accepted
//  res_ready  in   1      consumer accepts res_data when res_valid&res_ready
//  ovf        out  1      sticky: a window result was dropped (slot still full)
//  busy       out  1      1 while state==COUNT
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-window): state=IDLE; win_cnt=0; hit_cnt=0.
//    Outputs on reset: res_data=0, res_valid=0, ovf=0, busy=0. Takes effect immediately.
//  - Counter widths:
//    win_cnt is $clog2(WINDOW) bits; hit_cnt is CNT_W bits.
//  - FSM states:
//    IDLE: counters held at 0; en=1 -> COUNT on next edge; hit_in ignored.
//    COUNT: window cycles are indexed 0..WINDOW-1; win_cnt++ each cycle.
//      Each cycle: hit_cnt <= sat(hit_cnt + hit_in).
//      hit_cnt never wraps; it holds at 2**CNT_W-1.
//  - Window end (cycle WINDOW-1):
//    - final = sat(hit_cnt + hit_in), so a hit in the last cycle is counted.
//    - Slot free = (res_valid==0) | (res_valid & res_ready) in that cycle.
//    - Slot free: res_data<=final, res_valid<=1; visible the next cycle (1-cycle latency).
//    - Slot busy: res_data and res_valid unchanged; result dropped; ovf<=1.
//    - Counters <=0 in all cases.
//    - en=1 -> stay COUNT; the next window starts immediately, no gap cycle.
//    - en=0 -> IDLE.
//  - en deasserted mid-window: the current window runs to completion; no truncated result.
//  - Handshake:
//    - res_valid&res_ready with no new result that cycle -> res_valid<=0.
//    - res_data stays stable while res_valid=1 and res_ready=0.
//  - ovf clears only on reset.
//  - busy is a registered decode of state (busy=1 iff state==COUNT).
// STRUCTURE
//  - State encodings (IDLE=1'b0, COUNT=1'b1) are localparams local to the module.
//  - The shared fsm_defs.vh header holds only the saturating-add width helper macro.
//  - One sub-module: sat_inc_counter #(W), providing clear, inc and a saturating
//    W-bit count output; used for hit_cnt.
//  - win_cnt stays inline.
// TESTING  (WINDOW=8, CNT_W=4 unless noted)
//  1 Basic count: en=1, res_ready=1, hits at window cycles 1,3,7
//    -> res_valid=1 for 1 cycle after cycle 7, res_data=3, ovf=0.
//  2 Saturation: WINDOW=32, hit_in=1 continuously
//    -> res_data=15 each window, no wrap to 0.
//  3 Backpressure: res_ready=0 over 2 window ends (counts 2 then 5)
//    -> res_data stays 2, res_valid=1, ovf=1 after second end.
//    Then res_ready=1 -> accepted, ovf remains 1.
//  4 Same-cycle accept: res_valid=1, res_ready=1 at window end with count 4
//    -> res_valid stays 1, res_data=4, ovf=0.
//  5 Stop: en->0 at window cycle 3
//    -> window completes at cycle 7, result emitted, busy=0 next cycle, state IDLE.
//  6 Async reset at window cycle 5 with 2 hits counted, between clock edges
//    -> res_valid=0, busy=0 immediately.
//    After release + en=1 -> the next result counts only new hits.

Source files
------------

// File: rtl/seq_hit_window_counter_pkg.sv
// Shared definitions for the windowed hit counter: default parameter values
// and the helper that sizes the window-position counter.
`timescale 1ns/1ps
package seq_hit_window_counter_pkg;

  localparam int DEF_WINDOW = 16;
  localparam int DEF_CNT_W  = 8;

  // Bits needed to index window cycles 0..window-1; at least one bit.
  function automatic int win_cnt_width(input int window);
    return (window <= 2) ? 1 : $clog2(window);
  endfunction

endpackage

// File: rtl/seq_hit_window_counter_sat_inc_counter.sv
// Saturating W-bit up-counter with synchronous clear and a single-step
// increment. Holds at all-ones instead of wrapping.
`timescale 1ns/1ps
module sat_inc_counter
  import seq_hit_window_counter_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise add inc unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector match pulses over fixed windows of WINDOW cycles and
// publishes each window's saturated count on a valid/ready result port.
// A result that finds the output slot still occupied is dropped and the
// sticky ovf flag is raised.
`timescale 1ns/1ps
module seq_hit_window_counter
  import seq_hit_window_counter_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             hit_in,
  output logic [CNT_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int               WIN_W    = win_cnt_width(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  logic             state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             win_end;
  logic             slot_free;
  logic             hit_clear;
  logic             hit_inc;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] hit_final;

  assign win_end   = (state_q == ST_COUNT) && (win_cnt_q == WIN_LAST);
  assign slot_free = !res_valid_q || res_ready;

  // Hit counter is held at zero while idle and restarts at every window end.
  assign hit_clear = (state_q == ST_IDLE) || win_end;
  assign hit_inc   = (state_q == ST_COUNT) && hit_in;

  sat_inc_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .clear_i (hit_clear),
    .inc_i   (hit_inc),
    .cnt_o   (hit_cnt)
  );

  // Window total including a hit that lands in the final window cycle.
  assign hit_final = (hit_in && !(&hit_cnt)) ? hit_cnt + CNT_W'(1) : hit_cnt;

  // State and window-position register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  // Next state: en starts counting from idle; once running, en is only
  // looked at on the last window cycle so windows are never truncated.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (win_end) begin
          if (!en) begin
            state_d = ST_IDLE;
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: publish or drop at window end, retire on handshake.
  always_comb begin
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    ovf_d       = ovf_q;
    busy_d      = (state_d == ST_COUNT);
    if (win_end) begin
      if (slot_free) begin
        res_data_d  = hit_final;
        res_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule
